keymatrix_scan_8x8: RTL

Scans an 8x8 key/switch matrix: drives one row low at a time, samples the eight column inputs, debounces all 64 keys, and reports changes through a small event FIFO with a valid/ready handshake. It is the input-side counterpart of the 8x8 LED matrix driver path. The driver writes a 64-bit image out to rows/columns; this block reads a 64-bit key image back in. It sits between the board matrix pins and the consumer logic (MCU bridge, LED pattern control).

---
 rtl/keymatrix_scan_8x8.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/keymatrix_scan_8x8.sv
// keymatrix_scan_8x8: scans an 8x8 active-low key matrix, debounces all 64 keys and queues change events.
// Latency: a change is reported after DEBOUNCE_SCANS samples of its row; row period is SCAN_DIV+8 cycles.
// Backpressure: 4-deep event FIFO; a push into a full FIFO with no pop is dropped and sets sticky overflow. Releases are queued only with KEYMATRIX_RELEASE_EV_EN.

module keymatrix_ev_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // A full FIFO still takes a write when the head leaves on the same edge.
  assign out_vld = (count != '0);
  assign in_rdy  = (count != FULL_CNT) || out_rdy;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module keymatrix_scan_8x8 #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  row_drv,
  input  logic [7:0]  col_in,
  output logic [63:0] keys,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [6:0]  ev_code,
  output logic        overflow,
  input  logic        ovf_clr
);
  typedef enum logic {SETTLE, UPDATE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [2:0] DEB_N    = 3'(DEBOUNCE_SCANS);

  state_t     state;
  logic [7:0] col_meta;
  logic [7:0] col_sync;
  logic [7:0] sample;
  logic [7:0] div_cnt;
  logic [2:0] row;
  logic [2:0] col;
  logic [2:0] cnt [64];

  logic [5:0] key_idx;
  logic       key_new;
  logic       key_diff;
  logic [2:0] cnt_inc;
  logic       flip;
  logic       ev_push;
  logic       ev_push_rdy;

  // Columns are pulled up and free-running relative to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 8'hFF;
      col_sync <= 8'hFF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  assign key_idx  = {row, col};
  assign key_new  = sample[col];
  assign key_diff = (key_new != keys[key_idx]);
  assign cnt_inc  = cnt[key_idx] + 3'd1;
  assign flip     = (state == UPDATE) && key_diff && (cnt_inc == DEB_N);

`ifdef KEYMATRIX_RELEASE_EV_EN
  assign ev_push = flip;
`else
  assign ev_push = flip && key_new;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SETTLE;
      row     <= '0;
      col     <= '0;
      div_cnt <= '0;
      sample  <= '0;
      row_drv <= 8'hFE;
      keys    <= '0;
      for (int i = 0; i < 64; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        SETTLE: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sample  <= ~col_sync;
            col     <= '0;
            state   <= UPDATE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        UPDATE: begin
          if (!key_diff) begin
            cnt[key_idx] <= '0;
          end else if (cnt_inc == DEB_N) begin
            keys[key_idx] <= key_new;
            cnt[key_idx]  <= '0;
          end else begin
            cnt[key_idx] <= cnt_inc;
          end
          col <= col + 3'd1;
          if (col == 3'd7) begin
            row     <= row + 3'd1;
            row_drv <= ~(8'd1 << (row + 3'd1));
            state   <= SETTLE;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

  keymatrix_ev_fifo #(
    .WIDTH (7),
    .DEPTH (4)
  ) u_ev_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (ev_push),
    .in_rdy  (ev_push_rdy),
    .in_dat  ({key_new, key_idx}),
    .out_vld (ev_valid),
    .out_rdy (ev_ready),
    .out_dat (ev_code)
  );

  // A dropped event wins over a clear arriving on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ev_push && !ev_push_rdy) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
endmodule
